// File: rtl/mul_share_arb_if.sv
// rtl/mul_share_arb_if.sv - operand, multiplier and response bundle for mul_share_arb
interface mul_share_arb_if #(
  parameter int NREQ = 4,
  parameter int W    = 4
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_x;
  logic [NREQ*W-1:0] req_y;
  logic [W-1:0]      mul_x;
  logic [W-1:0]      mul_y;
  logic [2*W-1:0]    mul_z;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [2*W-1:0]    rsp_data;
  logic              busy;

  // Arbiter side
  modport slave (
    input  req_valid, req_x, req_y, mul_z, rsp_ready,
    output req_ready, mul_x, mul_y, rsp_valid, rsp_id, rsp_data, busy
  );

  // Requester / multiplier / consumer side
  modport master (
    output req_valid, req_x, req_y, mul_z, rsp_ready,
    input  req_ready, mul_x, mul_y, rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/mul_share_arb.sv
// rtl/mul_share_arb.sv - round-robin sharing of one multicycle multiplier; optional MUL_SHARE_ARB_ZERO_SKIP_EN
module mul_share_arb #(
  parameter int NREQ   = 4,
  parameter int W      = 4,
  parameter int SETTLE = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_share_arb_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = 4;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  rr_ptr;
  logic [CW-1:0]   cnt;
  logic [W-1:0]    x_q, y_q;
  logic [IDW-1:0]  id_q;
  logic [2*W-1:0]  data_q;
  logic            rsp_valid_q;

  logic [W-1:0]    rx [NREQ];
  logic [W-1:0]    ry [NREQ];
  logic [IDW-1:0]  gnt;
  logic [IDW-1:0]  idx;
  logic            gnt_found;
  logic [W-1:0]    sel_x, sel_y;
  logic            accept;
  logic [NREQ-1:0] req_ready_c;
`ifdef MUL_SHARE_ARB_ZERO_SKIP_EN
  logic            zero_op;
  assign zero_op = (sel_x == '0) || (sel_y == '0);
`endif

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign rx[i] = bus.req_x[i*W +: W];
    assign ry[i] = bus.req_y[i*W +: W];
  end

  // Round-robin winner: first valid requester at or after rr_ptr
  always_comb begin
    gnt       = '0;
    gnt_found = 1'b0;
    idx       = '0;
    sel_x     = '0;
    sel_y     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k >= NREQ) ? IDW'(int'(rr_ptr) + k - NREQ) : IDW'(int'(rr_ptr) + k);
      if (!gnt_found && bus.req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt       = idx;
        sel_x     = rx[idx];
        sel_y     = ry[idx];
      end
    end
  end

  // Next state and grant; a grant is only offered while idle and out of reset
  always_comb begin
    state_nxt   = state;
    req_ready_c = '0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_found && rst_n) begin
          req_ready_c[gnt] = 1'b1;
          accept           = 1'b1;
`ifdef MUL_SHARE_ARB_ZERO_SKIP_EN
          state_nxt        = zero_op ? RESP : CALC;
`else
          state_nxt        = CALC;
`endif
        end
      end
      CALC: begin
        if (cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Operand latch, settle counter, pointer rotation and response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      cnt         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      id_q        <= '0;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            x_q    <= sel_x;
            y_q    <= sel_y;
            id_q   <= gnt;
            cnt    <= CW'(SETTLE - 1);
            rr_ptr <= (gnt == IDW'(NREQ - 1)) ? '0 : gnt + IDW'(1);
`ifdef MUL_SHARE_ARB_ZERO_SKIP_EN
            if (zero_op) begin
              data_q      <= '0;
              rsp_valid_q <= 1'b1;
            end
`endif
          end
        end
        CALC: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            data_q      <= bus.mul_z;
            rsp_valid_q <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) rsp_valid_q <= 1'b0;
        end
        default: rsp_valid_q <= 1'b0;
      endcase
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.mul_x     = x_q;
  assign bus.mul_y     = y_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = data_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mul_share_arb.sv
// tb/tb_mul_share_arb.sv - randomized and directed bench for mul_share_arb against a transaction model
module tb_mul_share_arb;
  localparam int NREQ   = 4;
  localparam int W      = 4;
  localparam int SETTLE = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_share_arb_if #(.NREQ(NREQ), .W(W)) bus ();
  assign bus.mul_z = (2*W)'(bus.mul_x) * (2*W)'(bus.mul_y);

  mul_share_arb #(.NREQ(NREQ), .W(W), .SETTLE(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // stimulus
  logic [NREQ-1:0] v_valid;
  logic [W-1:0]    v_x [NREQ];
  logic [W-1:0]    v_y [NREQ];
  logic            v_rsp_ready;

  // transaction model: at most one outstanding job
  int m_ptr, m_id, m_data, m_x, m_y, m_due, m_acc;
  bit m_busy;
  int grants[$];
  int rsps[$];
  int last_id, last_data, last_lat, n_rsp;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic drive();
    bus.req_valid = v_valid;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_x[i*W +: W] = v_x[i];
      bus.req_y[i*W +: W] = v_y[i];
    end
    bus.rsp_ready = v_rsp_ready;
  endtask

  function automatic int due_for(input int x, input int y, input int now);
`ifdef MUL_SHARE_ARB_ZERO_SKIP_EN
    if (x == 0 || y == 0) return now + 1;
`endif
    return now + SETTLE + 1;
  endfunction

  // one clock: drive at negedge, check, predict the coming edge
  task automatic step();
    int g;
    bit rv_exp;
    drive();
    #1;
    g = -1;
    if (!m_busy)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && v_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    check_val("req_ready", int'(bus.req_ready), (g >= 0) ? (1 << g) : 0);
    check_val("busy", int'(bus.busy), int'(m_busy));
    rv_exp = m_busy && (cyc >= m_due);
    check_val("rsp_valid", int'(bus.rsp_valid), int'(rv_exp));
    check_val("mul_x", int'(bus.mul_x), m_x);
    check_val("mul_y", int'(bus.mul_y), m_y);
    if (rv_exp) begin
      check_val("rsp_id", int'(bus.rsp_id), m_id);
      check_val("rsp_data", int'(bus.rsp_data), m_data);
    end
    if (rv_exp && v_rsp_ready) begin
      m_busy    = 1'b0;
      last_id   = m_id;
      last_data = m_data;
      last_lat  = cyc - m_acc;
      n_rsp++;
      rsps.push_back(m_data);
    end else if (g >= 0) begin
      m_busy = 1'b1;
      m_id   = g;
      m_x    = int'(v_x[g]);
      m_y    = int'(v_y[g]);
      m_data = m_x * m_y;
      m_acc  = cyc;
      m_due  = due_for(m_x, m_y, cyc);
      m_ptr  = (g + 1) % NREQ;
      grants.push_back(g);
    end
    @(posedge clk);
    if (g >= 0) v_valid[g] = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_idle(input int max);
    bit done;
    done = 1'b0;
    for (int n = 0; n < max && !done; n++) begin
      if (!m_busy && v_valid == '0) done = 1'b1;
      else step();
    end
    if (!done) check_val("timeout", 1, 0);
  endtask

  // called at a negedge; reset is asynchronous so outputs must clear at once
  task automatic hard_reset();
    drive();
    rst_n = 1'b0;
    #1;
    check_val("rst_req_ready", int'(bus.req_ready), 0);
    check_val("rst_mul_x", int'(bus.mul_x), 0);
    check_val("rst_mul_y", int'(bus.mul_y), 0);
    check_val("rst_rsp_data", int'(bus.rsp_data), 0);
    check_val("rst_rsp_id", int'(bus.rsp_id), 0);
    check_val("rst_rsp_valid", int'(bus.rsp_valid), 0);
    check_val("rst_busy", int'(bus.busy), 0);
    m_ptr = 0; m_busy = 1'b0; m_x = 0; m_y = 0; m_due = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n0;
    v_valid = '0;
    v_rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin v_x[i] = '0; v_y[i] = '0; end
    n_rsp = 0;
    drive();
    repeat (2) @(negedge clk);
    hard_reset();

    // single request
    v_valid = 4'b0100; v_x[2] = 4'd13; v_y[2] = 4'd11;
    run_idle(50);
    check_val("t1_id", last_id, 2);
    check_val("t1_data", last_data, 143);
    check_val("t1_lat", last_lat, SETTLE + 1);

    // contention, fairness
    hard_reset();
    grants.delete(); rsps.delete();
    for (int i = 0; i < NREQ; i++) begin v_x[i] = W'(i + 1); v_y[i] = 4'd3; end
    v_valid = '1;
    run_idle(100);
    for (int i = 0; i < NREQ; i++) begin
      check_val("t2_order", grants[i], i);
      check_val("t2_prod", rsps[i], 3 * (i + 1));
    end
    v_valid = 4'b0101;
    run_idle(100);
    check_val("t2_regrant0", grants[4], 0);
    check_val("t2_regrant2", grants[5], 2);

    // backpressure
    hard_reset();
    grants.delete(); rsps.delete();
    v_x[1] = 4'd6; v_y[1] = 4'd7; v_x[3] = 4'd9; v_y[3] = 4'd2;
    v_valid = 4'b1010; v_rsp_ready = 1'b0;
    repeat (SETTLE + 6) step();
    v_rsp_ready = 1'b1;
    run_idle(100);
    check_val("t3_first", grants[0], 1);
    check_val("t3_second", grants[1], 3);
    check_val("t3_data1", rsps[0], 42);
    check_val("t3_data3", rsps[1], 18);

    // corner values
    v_valid = 4'b0001; v_x[0] = 4'd15; v_y[0] = 4'd15;
    run_idle(50);
    check_val("t4_max", last_data, 225);
    v_valid = 4'b0001; v_x[0] = 4'd15; v_y[0] = 4'd1;
    run_idle(50);
    check_val("t4_x15y1", last_data, 15);

    // reset in CALC
    v_valid = 4'b0001; v_x[0] = 4'd7; v_y[0] = 4'd7;
    step();
    step();
    n0 = n_rsp;
    v_valid = 4'b1000; v_x[3] = 4'd5; v_y[3] = 4'd5;
    hard_reset();
    check_val("t5_no_rsp", n_rsp, n0);
    run_idle(50);
    check_val("t5_id", last_id, 3);
    check_val("t5_data", last_data, 25);

    // zero operand
    v_valid = 4'b0010; v_x[1] = 4'd0; v_y[1] = 4'd9;
    run_idle(50);
    check_val("t6_data", last_data, 0);
`ifdef MUL_SHARE_ARB_ZERO_SKIP_EN
    check_val("t6_lat", last_lat, 1);
`else
    check_val("t6_lat", last_lat, SETTLE + 1);
`endif

    // random traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!v_valid[i] && ($urandom % 4) == 0) begin
          v_valid[i] = 1'b1;
          v_x[i] = ($urandom % 5 == 0) ? 4'd15 : W'($urandom_range(0, 15));
          v_y[i] = W'($urandom_range(0, 15));
        end
      v_rsp_ready = ($urandom % 3) != 0;
      step();
    end
    v_rsp_ready = 1'b1;
    run_idle(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
